// File: rtl/char_buf_pkg.sv
// Shared constants and FSM state type for the HDMI character buffer write path.
package char_buf_pkg;

  localparam int CHAR_ADDR_W = 8;
  localparam int CHAR_DATA_W = 8;
  localparam logic [CHAR_DATA_W-1:0] FILL_SPACE = 8'h20;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } wr_state_e;

endpackage

// File: rtl/char_wr_arbiter_rr_arb2.sv
// Two-way round-robin grant; last_grant resets to 1 so requester 0 wins the first contest.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic last_q;
  logic last_d;

  always_comb begin
    grant  = 2'b00;
    last_d = last_q;
    if (en) begin
      if (valid == 2'b11) begin
        grant = last_q ? 2'b01 : 2'b10;
      end else begin
        grant = valid;
      end
    end
    // A grant is only ever given to a valid requester, so every grant is a transfer.
    if (grant[0]) begin
      last_d = 1'b0;
    end else if (grant[1]) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/char_wr_arbiter.sv
// Char RAM write-port owner: round-robin between two requesters plus an optional
// full-RAM clear sequencer, enabled by defining CHAR_WR_ARB_CLEAR_EN.
module char_wr_arbiter
  import char_buf_pkg::*;
#(
  parameter int                ADDR_W    = CHAR_ADDR_W,
  parameter int                DATA_W    = CHAR_DATA_W,
  parameter logic [DATA_W-1:0] FILL_CHAR = DATA_W'(FILL_SPACE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              ram_cea,
  output logic [ADDR_W-1:0] ram_ada,
  output logic [DATA_W-1:0] ram_din
);

  logic              cea_q, cea_d;
  logic [ADDR_W-1:0] ada_q, ada_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              arb_en;
  logic [1:0]        grant;

`ifdef CHAR_WR_ARB_CLEAR_EN
  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // A clear request pre-empts any grant in the cycle it is seen.
  assign arb_en = (state_q == IDLE) && !clr_req;
`else
  logic unused_clr_req;

  assign unused_clr_req = clr_req;
  assign arb_en         = 1'b1;
`endif

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en),
    .valid ({req1_valid, req0_valid}),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    cea_d = 1'b0;
    ada_d = ada_q;
    din_d = din_q;
    if (grant[0]) begin
      cea_d = 1'b1;
      ada_d = req0_addr;
      din_d = req0_data;
    end else if (grant[1]) begin
      cea_d = 1'b1;
      ada_d = req1_addr;
      din_d = req1_data;
    end
`ifdef CHAR_WR_ARB_CLEAR_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cea_d = 1'b1;
        ada_d = cnt_q;
        din_d = FILL_CHAR;
        cnt_d = cnt_q + 1'b1;
        // Leave after the top address; the counter wrap is harmless since IDLE reloads it.
        if (cnt_q == '1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CLEAR);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cea_q <= 1'b0;
      ada_q <= '0;
      din_q <= '0;
    end else begin
      cea_q <= cea_d;
      ada_q <= ada_d;
      din_q <= din_d;
    end
  end

`ifdef CHAR_WR_ARB_CLEAR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign clr_busy = busy_q;
  assign clr_done = done_q;
`else
  assign clr_busy = 1'b0;
  assign clr_done = 1'b0;
`endif

  assign ram_cea = cea_q;
  assign ram_ada = ada_q;
  assign ram_din = din_q;

endmodule

// File: tb/tb_char_wr_arbiter.sv
// Randomized bench for char_wr_arbiter against a count-based reference model; follows CHAR_WR_ARB_CLEAR_EN.
module tb_char_wr_arbiter;

  localparam int DEPTH = 256;
  localparam logic [7:0] FILL = 8'h20;
`ifdef CHAR_WR_ARB_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_addr, req0_data, req1_addr, req1_data;
  logic       req0_ready, req1_ready;
  logic       clr_req, clr_busy, clr_done;
  logic       ram_cea;
  logic [7:0] ram_ada, ram_din;

  char_wr_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .ram_cea    (ram_cea),
    .ram_ada    (ram_ada),
    .ram_din    (ram_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: clear writes still owed, and who was served last.
  int         m_left;
  int         m_last;
  bit         e_r0, e_r1;
  logic       e_cea, e_busy, e_done;
  logic [7:0] e_ada, e_din;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left = 0;
    m_last = 1;
    e_cea  = 1'b0;
    e_ada  = 8'h00;
    e_din  = 8'h00;
    e_busy = 1'b0;
    e_done = 1'b0;
    e_r0   = 1'b0;
    e_r1   = 1'b0;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "ram_cea"},  ram_cea,  e_cea);
    check({pfx, "ram_ada"},  ram_ada,  e_ada);
    check({pfx, "ram_din"},  ram_din,  e_din);
    check({pfx, "clr_busy"}, clr_busy, e_busy);
    check({pfx, "clr_done"}, clr_done, e_done);
  endtask

  // One clock: called just after a falling edge, returns just after the next one.
  task automatic step(input bit v0, input logic [7:0] a0, input logic [7:0] d0,
                      input bit v1, input logic [7:0] a1, input logic [7:0] d1,
                      input bit clr);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    clr_req    = clr;
    #1;
    e_r0 = 1'b0;
    e_r1 = 1'b0;
    if (m_left == 0 && !(CLR_EN && clr)) begin
      if (v0 && v1) begin
        if (m_last == 1) e_r0 = 1'b1;
        else             e_r1 = 1'b1;
      end else begin
        e_r0 = v0;
        e_r1 = v1;
      end
    end
    check("req0_ready", req0_ready, e_r0);
    check("req1_ready", req1_ready, e_r1);
    e_done = (m_left == 1);
    e_cea  = 1'b0;
    if (m_left > 0) begin
      e_cea  = 1'b1;
      e_ada  = 8'(DEPTH - m_left);
      e_din  = FILL;
      m_left = m_left - 1;
    end else if (CLR_EN && clr) begin
      m_left = DEPTH;
    end else if (e_r0) begin
      e_cea = 1'b1; e_ada = a0; e_din = d0; m_last = 0;
      $display("xfer req0 addr=%02h data=%02h", a0, d0);
    end else if (e_r1) begin
      e_cea = 1'b1; e_ada = a1; e_din = d1; m_last = 1;
      $display("xfer req1 addr=%02h data=%02h", a1, d1);
    end
    e_busy = (m_left > 0);
    @(negedge clk);
    check_outputs("");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic async_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    clr_req    = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("rst_");
    @(negedge clk);
    reset = 1'b0;
  endtask

  bit         h_v0, h_v1, keep0, keep1, acc1;
  logic [7:0] h_a0, h_d0, h_a1, h_d1;

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_addr = 8'h00; req0_data = 8'h00;
    req1_valid = 1'b0; req1_addr = 8'h00; req1_data = 8'h00;
    clr_req = 1'b0;
    model_reset();
    #1;
    check_outputs("rst_");
    @(negedge clk);
    reset = 1'b0;

    // Single write right after reset, then a req1 write so the both-valid burst starts with req0.
    step(1'b1, 8'h10, 8'h41, 1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b1, 8'h22, 8'h55, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h30, 8'h61, 1'b1, 8'h31, 8'h62, 1'b0);
    idle(2);

    // Clear together with a req1 request that stays pending until accepted.
    acc1 = 1'b0;
    step(1'b0, 8'h00, 8'h00, 1'b1, 8'h40, 8'h42, 1'b1);
    if (e_r1) acc1 = 1'b1;
    for (int i = 0; i < 262; i++) begin
      step(1'b0, 8'h00, 8'h00, !acc1, 8'h40, 8'h42, 1'b0);
      if (e_r1) acc1 = 1'b1;
    end
    check("req1_accepted", acc1, 1'b1);

    // Reset while the clear sits at address 100, then a fresh clear from 0.
    step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    idle(101);
    async_reset();
    step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    idle(3);

    // Second clr_req at address 50 must not restart the sequence.
    idle(260);
    step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    idle(51);
    step(1'b1, 8'h05, 8'h77, 1'b0, 8'h00, 8'h00, 1'b1);
    idle(210);

    // Random traffic; a requester keeps addr/data stable until the model says it was accepted.
    h_v0 = 1'b0; h_v1 = 1'b0; keep0 = 1'b0; keep1 = 1'b0;
    h_a0 = 8'h00; h_d0 = 8'h00; h_a1 = 8'h00; h_d1 = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if (!keep0) begin
        h_v0 = ($urandom_range(0, 99) < 60);
        h_a0 = 8'($urandom_range(0, 255));
        h_d0 = 8'($urandom_range(0, 255));
      end
      if (!keep1) begin
        h_v1 = ($urandom_range(0, 99) < 60);
        h_a1 = 8'($urandom_range(0, 255));
        h_d1 = 8'($urandom_range(0, 255));
      end
      step(h_v0, h_a0, h_d0, h_v1, h_a1, h_d1, ($urandom_range(0, 999) < 3));
      keep0 = h_v0 && !e_r0;
      keep1 = h_v1 && !e_r1;
    end
    idle(260);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
